// File: rtl/pace_pingpong_oup_if.sv
// Stream handshake bundle for packed output words.
// Carries data, byte strobe, valid and ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );
endinterface

// File: rtl/pace_pingpong_oup.sv
// Packs engine beats into full output words, then queues them in a 2-entry FIFO.
// Define PACE_PINGPONG_OUP_FLUSH_EN to emit partial words on last_i.
module pace_pingpong_oup #(
  parameter int unsigned OupDataWidth   = 256,
  parameter int unsigned NumRows        = 8,
  parameter int unsigned CEInpDataWidth = 16,
  parameter int unsigned InpDataWidth   = NumRows * CEInpDataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic [InpDataWidth-1:0] input_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    last_i,
  hwpe_stream_intf_stream.source  output_o
);

  localparam int unsigned NumStreams = OupDataWidth / InpDataWidth;
  localparam int unsigned SliceStrb  = InpDataWidth / 8;
  localparam int unsigned StrbWidth  = OupDataWidth / 8;
  localparam int unsigned CntWidth   = $clog2(NumStreams);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumStreams - 1);

  if (NumStreams < 2 || NumStreams * InpDataWidth != OupDataWidth) begin : g_bad_cfg
    $error("OupDataWidth must be an integer multiple >= 2 of InpDataWidth");
  end

  logic [CntWidth-1:0]                     beat_cnt;
  logic [NumStreams-2:0][InpDataWidth-1:0] pack_q;

  logic [1:0]              fifo_cnt;
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [OupDataWidth-1:0] fifo_data [2];
  logic [StrbWidth-1:0]    fifo_strb [2];

  logic                    full_beat;
  logic                    last_beat;
  logic                    fifo_full;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [OupDataWidth-1:0] word_data;
  logic [StrbWidth-1:0]    word_strb;

  assign full_beat = beat_cnt == LastCnt;
  assign fifo_full = fifo_cnt == 2'd2;
  assign wr_ptr    = rd_ptr ^ fifo_cnt[0];

`ifdef PACE_PINGPONG_OUP_FLUSH_EN
  // A flushing beat always pushes, so it needs FIFO room regardless of slot.
  assign last_beat = last_i;
  assign ready_o   = enable_i & ((valid_i & last_i) ? !fifo_full
                                                    : (!full_beat | !fifo_full));
`else
  logic unused_last;
  assign unused_last = last_i;
  assign last_beat   = 1'b0;
  assign ready_o     = enable_i & (!full_beat | !fifo_full);
`endif

  assign accept = valid_i & ready_o;
  assign push   = accept & (full_beat | last_beat);
  assign pop    = output_o.valid & output_o.ready;

  // Slices below beat_cnt come from the pack register; slots above stay zero.
  always_comb begin
    word_data = '0;
    word_strb = '0;
    for (int s = 0; s < NumStreams - 1; s++) begin
      if (s < int'(beat_cnt)) begin
        word_data[s*InpDataWidth +: InpDataWidth] = pack_q[s];
        word_strb[s*SliceStrb +: SliceStrb]       = '1;
      end
    end
    for (int s = 0; s < NumStreams; s++) begin
      if (s == int'(beat_cnt)) begin
        word_data[s*InpDataWidth +: InpDataWidth] = input_i;
        word_strb[s*SliceStrb +: SliceStrb]       = '1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      beat_cnt  <= '0;
      pack_q    <= '0;
      fifo_cnt  <= '0;
      rd_ptr    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_strb[i] <= '0;
      end
    end else begin
      if (push) begin
        beat_cnt          <= '0;
        fifo_data[wr_ptr] <= word_data;
        fifo_strb[wr_ptr] <= word_strb;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        for (int s = 0; s < NumStreams - 1; s++) begin
          if (s == int'(beat_cnt)) pack_q[s] <= input_i;
        end
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign output_o.valid = fifo_cnt != 2'd0;
  assign output_o.data  = fifo_data[rd_ptr];
  assign output_o.strb  = fifo_strb[rd_ptr];

`ifndef SYNTHESIS
  property p_hold;
    @(posedge clk_i) disable iff (rst_i || clear_i)
      valid_i && !ready_o |=> valid_i && $stable(input_i) && $stable(last_i);
  endproperty
  a_hold: assert property (p_hold)
    else $error("beat dropped or changed before acceptance");
`endif

endmodule

// File: tb/tb_pace_pingpong_oup.sv
// Randomized bench for pace_pingpong_oup against a beat/word queue model.
// Covers reset, backpressure, streaming, enable stall, clear and last_i.
module tb_pace_pingpong_oup;
  localparam int OW = 256;
  localparam int IW = 128;
  localparam int N  = OW / IW;
  localparam int SW = OW / 8;
`ifdef PACE_PINGPONG_OUP_FLUSH_EN
  localparam bit Flush = 1'b1;
`else
  localparam bit Flush = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr, en, vld, lst, rdy;
  logic [IW-1:0] beat;

  hwpe_stream_intf_stream #(.DATA_WIDTH(OW)) out_if ();

  pace_pingpong_oup dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clr),
    .enable_i (en),
    .input_i  (beat),
    .valid_i  (vld),
    .ready_o  (rdy),
    .last_i   (lst),
    .output_o (out_if)
  );

  int checks = 0;
  int errors = 0;

  logic          s_rst, s_clr, s_en, s_vld, s_lst, s_srdy;
  logic [IW-1:0] s_beat;

  logic          obs_ready, obs_valid, exp_ready, exp_valid;
  logic [OW-1:0] obs_data, exp_data;
  logic [SW-1:0] obs_strb, exp_strb;
  logic          m_acc, m_pop;

  logic [IW-1:0] part [$];
  logic [OW-1:0] wq_d [$];
  logic [SW-1:0] wq_s [$];

  function automatic logic [IW-1:0] rb();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive at negedge, sample, then advance the model.
  task automatic tick();
    logic [OW-1:0] w;
    logic [SW-1:0] st;
    @(negedge clk);
    rst = s_rst; clr = s_clr; en = s_en; vld = s_vld;
    lst = s_lst; beat = s_beat; out_if.ready = s_srdy;
    #1;
    obs_ready = rdy;
    obs_valid = out_if.valid;
    obs_data  = out_if.data;
    obs_strb  = out_if.strb;
    if (Flush && s_vld && s_lst)
      exp_ready = s_en && wq_d.size() < 2;
    else
      exp_ready = s_en && (part.size() != N - 1 || wq_d.size() < 2);
    exp_valid = wq_d.size() != 0;
    exp_data  = exp_valid ? wq_d[0] : '0;
    exp_strb  = exp_valid ? wq_s[0] : '0;
    m_acc = s_vld && exp_ready;
    m_pop = exp_valid && s_srdy;
    if (s_rst || s_clr) begin
      part.delete(); wq_d.delete(); wq_s.delete();
      m_acc = 1'b0; m_pop = 1'b0;
    end else begin
      if (m_pop) begin
        void'(wq_d.pop_front());
        void'(wq_s.pop_front());
      end
      if (m_acc) begin
        part.push_back(s_beat);
        if (part.size() == N || (Flush && s_lst)) begin
          w = '0; st = '0;
          foreach (part[i]) begin
            w[i*IW +: IW]      = part[i];
            st[i*(IW/8) +: IW/8] = '1;
          end
          wq_d.push_back(w);
          wq_s.push_back(st);
          part.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    s_rst = 1; s_clr = 0; s_en = 1; s_vld = 0; s_lst = 0;
    s_srdy = 0; s_beat = '0;
    repeat (3) tick();
    s_rst = 0;
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_data !== '0 || obs_strb !== '0) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h strb=%h want 0", obs_valid, obs_data, obs_strb);
    end
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", obs_ready);
    end
    s_en = 0;
    tick();
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_en0 got %b want 0", obs_ready);
    end
    s_en = 1;
  endtask

  task automatic test_basic();
    logic [IW-1:0] a, b;
    for (int r = 0; r < 8; r++) begin
      a[r*16 +: 16] = 16'h0001 + 16'(r);
      b[r*16 +: 16] = 16'h0011 + 16'(r);
    end
    s_srdy = 1; s_vld = 1;
    for (int k = 0; k < 3; k++) begin
      s_beat = (k == 0) ? a : b;
      if (k == 2) s_vld = 0;
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL basic_hs ready=%b/%b valid=%b/%b", obs_ready, exp_ready, obs_valid, exp_valid);
      end
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== {b, a} || obs_strb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL basic_word valid=%b data=%h strb=%h want %h", obs_valid, obs_data, obs_strb, {b, a});
    end
    tick();
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain valid=%b want 0", obs_valid);
    end
  endtask

  task automatic test_backpressure();
    int acc_n, dut_acc, first_acc, pops;
    acc_n = 0; dut_acc = 0; first_acc = -1; pops = 0;
    s_srdy = 0; s_vld = 1; s_beat = rb();
    repeat (10) begin
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL bp_hs ready=%b/%b valid=%b/%b", obs_ready, exp_ready, obs_valid, exp_valid);
      end
      if (s_vld && obs_ready) dut_acc++;
      if (m_acc) begin acc_n++; s_beat = rb(); end
    end
    checks++;
    if (dut_acc !== 5 || obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill accepted=%0d want 5 ready=%b want 0", dut_acc, obs_ready);
    end
    s_srdy = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL bp_rel_hs ready=%b/%b valid=%b/%b", obs_ready, exp_ready, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (obs_data !== exp_data || obs_strb !== exp_strb) begin
          errors++;
          $display("FAIL bp_data got %h want %h strb %h/%h", obs_data, exp_data, obs_strb, exp_strb);
        end
      end
      if (s_vld && obs_ready && first_acc < 0) first_acc = c;
      if (obs_valid) pops++;
      if (m_acc) s_vld = 0;
    end
    checks++;
    if (first_acc !== 1 || pops !== 3) begin
      errors++;
      $display("FAIL bp_release accept_cycle=%0d want 1 pops=%0d want 3", first_acc, pops);
    end
  endtask

  task automatic test_back_to_back();
    int sent, rx, last_v, max_gap;
    sent = 0; rx = 0; last_v = -1; max_gap = 0;
    s_srdy = 1; s_vld = 1; s_beat = rb();
    for (int c = 0; c < 70; c++) begin
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_hs ready=%b/%b valid=%b/%b", obs_ready, exp_ready, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (obs_data !== exp_data || obs_strb !== exp_strb) begin
          errors++;
          $display("FAIL b2b_data got %h want %h", obs_data, exp_data);
        end
      end
      if (obs_valid) begin
        rx++;
        if (last_v >= 0 && c - last_v - 1 > max_gap) max_gap = c - last_v - 1;
        last_v = c;
      end
      if (m_acc) begin
        sent++;
        s_beat = rb();
        if (sent == 64) s_vld = 0;
      end
    end
    checks++;
    if (rx !== 32 || max_gap > 1) begin
      errors++;
      $display("FAIL b2b_rate words=%0d want 32 gap=%0d want <=1", rx, max_gap);
    end
  endtask

  task automatic test_enable();
    int pops;
    pops = 0;
    s_srdy = 0; s_vld = 1;
    repeat (3) begin
      s_beat = rb();
      tick();
    end
    s_en = 0; s_srdy = 1; s_beat = rb();
    repeat (5) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0 || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL en_stall ready=%b want 0 valid=%b/%b", obs_ready, obs_valid, exp_valid);
      end
      if (obs_valid) pops++;
    end
    checks++;
    if (pops !== 1) begin
      errors++; $display("FAIL en_pop pops=%0d want 1", pops);
    end
    s_en = 1;
    repeat (4) begin
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL en_resume ready=%b/%b valid=%b/%b", obs_ready, exp_ready, obs_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (obs_data !== exp_data || obs_strb !== exp_strb) begin
          errors++;
          $display("FAIL en_data got %h want %h", obs_data, exp_data);
        end
      end
      if (m_acc) s_vld = 0;
    end
  endtask

  task automatic test_clear();
    logic [IW-1:0] b1, b2;
    s_srdy = 0; s_vld = 1;
    repeat (3) begin
      s_beat = rb();
      tick();
    end
    s_vld = 0; s_clr = 1;
    tick();
    s_clr = 0;
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_state valid=%b want 0 ready=%b want 1", obs_valid, obs_ready);
    end
    b1 = rb(); b2 = rb();
    s_srdy = 1; s_vld = 1; s_beat = b1;
    tick();
    s_beat = b2;
    tick();
    s_vld = 0;
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== {b2, b1} || obs_strb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL clr_fresh valid=%b data=%h want %h", obs_valid, obs_data, {b2, b1});
    end
    tick();
  endtask

  task automatic test_last();
    logic [IW-1:0] b1, b2;
    b1 = rb(); b2 = rb();
    s_srdy = 1; s_vld = 1; s_lst = 1; s_beat = b1;
    tick();
    s_vld = 0; s_lst = 0;
    tick();
`ifdef PACE_PINGPONG_OUP_FLUSH_EN
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== {{IW{1'b0}}, b1} || obs_strb !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL last_flush valid=%b data=%h strb=%h want strb 0000ffff", obs_valid, obs_data, obs_strb);
    end
    tick();
`else
    repeat (3) begin
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++; $display("FAIL last_ignored valid=%b want 0", obs_valid);
      end
      tick();
    end
    s_vld = 1; s_beat = b2;
    tick();
    s_vld = 0;
    tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== {b2, b1} || obs_strb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL last_pair valid=%b data=%h want %h", obs_valid, obs_data, {b2, b1});
    end
    tick();
`endif
  endtask

  task automatic test_random();
    s_vld = 0; s_lst = 0;
    for (int i = 0; i < 400; i++) begin
      s_en   = $urandom_range(0, 3) != 0;
      s_srdy = $urandom_range(0, 2) != 0;
      s_rst  = (i == 200);
      if (!s_vld) begin
        s_vld  = $urandom_range(0, 1) == 1;
        s_beat = rb();
        s_lst  = $urandom_range(0, 3) == 0;
      end
      tick();
      if (!s_rst) begin
        checks++;
        if (obs_ready !== exp_ready || obs_valid !== exp_valid) begin
          errors++;
          $display("FAIL rnd_hs i=%0d ready=%b/%b valid=%b/%b", i, obs_ready, exp_ready, obs_valid, exp_valid);
        end
        if (exp_valid) begin
          checks++;
          if (obs_data !== exp_data || obs_strb !== exp_strb) begin
            errors++;
            $display("FAIL rnd_data i=%0d got %h want %h strb %h/%h", i, obs_data, exp_data, obs_strb, exp_strb);
          end
        end
      end
      if (m_acc) s_vld = 0;
    end
    s_rst = 0; s_vld = 0; s_lst = 0; s_en = 1;
  endtask

  initial begin
    rst = 1; clr = 0; en = 0; vld = 0; lst = 0; beat = '0;
    out_if.ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_clear();
    test_last();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pace_pingpong_oup.md
# pace_pingpong_oup

Packs engine result beats (NumRows × CEInpDataWidth) into full-width memory words (OupDataWidth) over NumStreams consecutive accepted beats, then buffers them in a 2-entry FIFO towards the streamer sink. It sits between the PACE engine output and the HWPE store streamer. It is the write-side counterpart of the input ping-pong splitter: beat 0 fills the least-significant slice, so a word split by the input side and packed by this block is bit-identical.

## Interface
- InpDataWidth (NumRows*CEInpDataWidth): derived width of one beat.
- OupDataWidth, default 256: width of the packed output word.
- NumRows, default 8: engine rows per beat.
- CEInpDataWidth, default 16: bits per row result.
- NumStreams (OupDataWidth/InpDataWidth, localparam): beats per word; must be ≥ 2 and an exact integer.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear, same effect as rst_i.
- enable_i  in  1  gates input acceptance.
- input_i  in  NumRows×CEInpDataWidth  row results; row r maps to beat bits [CEInpDataWidth*(r+1)-1 -: CEInpDataWidth].
- valid_i  in  1  beat valid.
- ready_o  out  1  beat accepted when valid_i & ready_o.
- last_i  in  1  final beat of the tile; only honoured with the flush feature.
- output_o  hwpe_stream_intf_stream.source, DATA_WIDTH=OupDataWidth: packed words with data, strb (OupDataWidth/8), valid and ready.

## Operation
- State: beat_cnt (0..NumStreams-1), pack_q (NumStreams-1 slices plus a byte strobe), and a 2-entry FIFO (2-bit count, 1-bit read pointer).
- An accepted beat with beat_cnt < NumStreams-1 writes slice beat_cnt of pack_q and increments beat_cnt.
- An accepted beat with beat_cnt == NumStreams-1 pushes {beat, pack_q slices} into the FIFO with strb all-ones and sets beat_cnt to 0.
- ready_o = enable_i & (beat_cnt != NumStreams-1 | fifo_count < 2). ready_o uses registered state only and has no combinational path from output_o.ready.
- A FIFO pop and a FIFO push in the same cycle keep the count unchanged. This case is legal at count 1. At count 2 a push is blocked, even if a pop happens that cycle.
- output_o.valid = fifo_count != 0. output_o.data and output_o.strb come from the FIFO head.
- enable_i low stalls input only; the FIFO keeps draining.
- valid_i must stay asserted and the beat must stay stable until it is accepted. A violation is flagged by a simulation-only assertion.

## Timing
- Reset or clear: beat_cnt=0, pack_q and strobes=0, FIFO empty. Therefore output_o.valid=0, output_o.data=0, output_o.strb=0, and ready_o=enable_i in the next cycle.
- Latency: the final beat accepted at edge t makes output_o.valid=1 after edge t, i.e. visible in cycle t+1.
- Throughput: with the sink always ready, one word per NumStreams cycles and no bubbles.
- Reset or clear mid-word discards the partial pack and all FIFO contents with no output.
- Reset has priority over clear. Clear has priority over a simultaneous accept or pop.

## Configuration
- PACE_PINGPONG_OUP_FLUSH_EN defined:
  - An accepted beat with last_i=1 and beat_cnt < NumStreams-1 pushes the partial word immediately.
  - Unfilled slices are 0 and their strb bits are 0. beat_cnt returns to 0.
  - This push needs fifo_count < 2, so ready_o = enable_i & fifo_count < 2 whenever valid_i & last_i.
- Not defined: last_i is ignored, only full words are emitted, and strb is always all-ones.

## Test plan
- Reset, then feed 2 beats A=0x0001..0x0008 and B=0x0011..0x0018 (row r = base+r) with sink ready → one word in cycle t+1: low 128b = A rows in order, high 128b = B rows, strb=0xFFFFFFFF.
- Sink held not-ready while 6 beats are offered → FIFO fills with 2 words and ready_o drops exactly when beat_cnt=1. Releasing ready drains 2 words in order, then accepts the 6th beat.
- Continuous valid with sink always ready for 64 beats → 32 words with no gap longer than 1 cycle between words and no dropped or duplicated slices (scoreboard against the model).
- enable_i=0 for 5 cycles mid-word (beat_cnt=1) with a word already in the FIFO → no beat accepted, FIFO pops normally, packing resumes in the correct slice.
- clear_i asserted with beat_cnt=1 and 1 word queued → next cycle output_o.valid=0, and the next 2 beats form a fresh word.
- FLUSH_EN build: a single beat with last_i=1 → word with high 128b=0 and strb=0x0000FFFF. Non-FLUSH build, same stimulus → no output until a second beat arrives.
